// File: rtl/trap_sequencer.sv
// Z80 bus-side trap detector and NMI jump injector for the MegaMapper virtual mode.
// Optional TRAP_WRDATA_EN: capture OUT data into trap_data (otherwise trap_data reads 8'h00).
module trap_sequencer #(
    parameter logic [7:0]  TRAP_LO      = 8'h00,
    parameter logic [7:0]  TRAP_HI      = 8'hFF,
    parameter logic [15:0] NMI_VECTOR   = 16'h0066,
    parameter logic [15:0] HANDLER_ADDR = 16'h0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        virtual_mode,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    output logic        trap_condition,
    output logic [7:0]  trap_port,
    output logic        trap_dir,
    output logic [7:0]  trap_data,
    output logic        trap_overrun,
    output logic        new_isr,
    output logic        last_isr_jmp,
    output logic        inject_en,
    output logic [7:0]  inject_data
);

    typedef enum logic [2:0] {IDLE, ARMED, OP, LO, HI} state_t;

    state_t      state;
    logic        s_m1_n, s_mreq_n, s_iorq_n, s_rd_n, s_wr_n;
    logic        p_mreq_n, p_iorq_n;
    logic [15:0] s_addr;
    logic        cyc_fetch, cyc_mrd, trap_in_rd;
    logic [7:0]  seq_byte;

    logic        io_start, mem_start, fetch_start, mreq_end, iorq_end;
    logic        fetch_end, mrd_end, in_window, hit, nmi_fetch;
    logic        seq_busy_nxt, mem_rd_now, trap_in_now;
    logic [8:0]  lo_diff, hi_diff;
    logic [7:0]  seq_byte_nxt;

    always_comb begin
        io_start    = !s_iorq_n && p_iorq_n && s_m1_n;
        mem_start   = !s_mreq_n && p_mreq_n && !s_rd_n;
        fetch_start = mem_start && !s_m1_n;
        mreq_end    = s_mreq_n && !p_mreq_n;
        iorq_end    = s_iorq_n && !p_iorq_n;
        fetch_end   = mreq_end && cyc_fetch;
        mrd_end     = mreq_end && cyc_mrd;
        // Borrow bits give the window test without constant-compare warnings at default bounds.
        lo_diff     = {1'b0, s_addr[7:0]} - {1'b0, TRAP_LO};
        hi_diff     = {1'b0, TRAP_HI} - {1'b0, s_addr[7:0]};
        in_window   = !lo_diff[8] && !hi_diff[8];
        hit         = io_start && virtual_mode && in_window;
        nmi_fetch   = (state == ARMED) && fetch_start && (s_addr == NMI_VECTOR);

        seq_busy_nxt = nmi_fetch || (state == OP) || (state == LO) ||
                       ((state == HI) && !mrd_end);
        mem_rd_now   = (mem_start || cyc_fetch || cyc_mrd) && !s_rd_n && !mreq_end;
        trap_in_now  = (hit && !s_rd_n) || (trap_in_rd && !s_rd_n && !iorq_end);

        seq_byte_nxt = seq_byte;
        if (nmi_fetch)
            seq_byte_nxt = 8'hC3;
        else if ((state == OP) && fetch_end)
            seq_byte_nxt = HANDLER_ADDR[7:0];
        else if ((state == LO) && mrd_end)
            seq_byte_nxt = HANDLER_ADDR[15:8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            s_m1_n         <= 1'b1;
            s_mreq_n       <= 1'b1;
            s_iorq_n       <= 1'b1;
            s_rd_n         <= 1'b1;
            s_wr_n         <= 1'b1;
            p_mreq_n       <= 1'b1;
            p_iorq_n       <= 1'b1;
            s_addr         <= 16'h0000;
            cyc_fetch      <= 1'b0;
            cyc_mrd        <= 1'b0;
            trap_in_rd     <= 1'b0;
            seq_byte       <= 8'h00;
            trap_condition <= 1'b0;
            trap_port      <= 8'h00;
            trap_dir       <= 1'b0;
            trap_overrun   <= 1'b0;
            new_isr        <= 1'b0;
            last_isr_jmp   <= 1'b0;
            inject_en      <= 1'b0;
            inject_data    <= 8'h00;
        end else begin
            s_m1_n       <= m1_n;
            s_mreq_n     <= mreq_n;
            s_iorq_n     <= iorq_n;
            s_rd_n       <= rd_n;
            s_wr_n       <= wr_n;
            p_mreq_n     <= s_mreq_n;
            p_iorq_n     <= s_iorq_n;
            s_addr       <= addr;
            new_isr      <= 1'b0;
            last_isr_jmp <= 1'b0;

            if (mem_start) begin
                cyc_fetch <= !s_m1_n;
                cyc_mrd   <= s_m1_n;
            end else if (mreq_end) begin
                cyc_fetch <= 1'b0;
                cyc_mrd   <= 1'b0;
            end

            if (hit && !s_rd_n)
                trap_in_rd <= 1'b1;
            else if (iorq_end)
                trap_in_rd <= 1'b0;

            seq_byte    <= seq_byte_nxt;
            // A trapped IN overrides the jump byte only for the duration of that read.
            inject_en   <= trap_in_now || (mem_rd_now && seq_busy_nxt);
            inject_data <= trap_in_now ? 8'hFF : seq_byte_nxt;

            // Covers completion and hit in the same cycle: HI is not IDLE, so the hit drops.
            if (hit && (state != IDLE))
                trap_overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (hit) begin
                        trap_port      <= s_addr[7:0];
                        trap_dir       <= !s_wr_n;
                        trap_condition <= 1'b1;
                        state          <= ARMED;
                    end
                end
                ARMED: begin
                    if (nmi_fetch) begin
                        new_isr <= 1'b1;
                        state   <= OP;
                    end
                end
                OP: begin
                    if (fetch_end)
                        state <= LO;
                end
                LO: begin
                    if (mrd_end)
                        state <= HI;
                end
                HI: begin
                    if (mrd_end) begin
                        last_isr_jmp   <= 1'b1;
                        trap_condition <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TRAP_WRDATA_EN
    logic [7:0] s_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_data    <= 8'h00;
            trap_data <= 8'h00;
        end else begin
            s_data <= data_in;
            if ((state == IDLE) && hit && !s_wr_n)
                trap_data <= s_data;
        end
    end
`else
    logic unused_data;
    assign unused_data = ^data_in;
    assign trap_data   = 8'h00;
`endif

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: trap window 0x40-0x4F, NMI at 0x0066, handler 0x0100.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        virtual_mode = 1'b0;
    logic        m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  data_in = 8'h00;
    logic        trap_condition, trap_dir, trap_overrun, new_isr, last_isr_jmp, inject_en;
    logic [7:0]  trap_port, trap_data, inject_data;

    int total = 0;
    int bad = 0;
    int n_new = 0;
    int n_last = 0;

`ifdef TRAP_WRDATA_EN
    localparam logic [7:0] EXP_WD = 8'h5A;
`else
    localparam logic [7:0] EXP_WD = 8'h00;
`endif

    always #5 clk = ~clk;

    trap_sequencer #(
        .TRAP_LO(8'h40), .TRAP_HI(8'h4F), .NMI_VECTOR(16'h0066), .HANDLER_ADDR(16'h0100)
    ) dut (
        .clk(clk), .rst(rst), .virtual_mode(virtual_mode),
        .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .addr(addr), .data_in(data_in),
        .trap_condition(trap_condition), .trap_port(trap_port), .trap_dir(trap_dir),
        .trap_data(trap_data), .trap_overrun(trap_overrun), .new_isr(new_isr),
        .last_isr_jmp(last_isr_jmp), .inject_en(inject_en), .inject_data(inject_data)
    );

    always @(posedge clk) begin
        if (new_isr)      n_new  <= n_new + 1;
        if (last_isr_jmp) n_last <= n_last + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic io_out(input logic [15:0] a, input logic [7:0] d);
        addr = a; data_in = d; iorq_n = 1'b0; wr_n = 1'b0;
    endtask

    task automatic io_in(input logic [15:0] a);
        addr = a; iorq_n = 1'b0; rd_n = 1'b0;
    endtask

    task automatic mem_rd(input logic [15:0] a, input logic is_fetch);
        addr = a; m1_n = !is_fetch; mreq_n = 1'b0; rd_n = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(3);
        chk("rst_cond", 16'(trap_condition), 16'h0);
        chk("rst_inj_en", 16'(inject_en), 16'h0);
        chk("rst_inj_data", 16'(inject_data), 16'h00);
        chk("rst_port", 16'(trap_port), 16'h00);
        chk("rst_ovr", 16'(trap_overrun), 16'h0);
        chk("rst_data", 16'(trap_data), 16'h00);
        rst = 1'b0;
        tick(2);

        // Trapped OUT 0x41 <- 0x5A
        virtual_mode = 1'b1;
        io_out(16'h0041, 8'h5A);
        tick(2);
        chk("out_cond", 16'(trap_condition), 16'h1);
        chk("out_port", 16'(trap_port), 16'h41);
        chk("out_dir", 16'(trap_dir), 16'h1);
        chk("out_data", 16'(trap_data), 16'(EXP_WD));
        chk("out_inj_en", 16'(inject_en), 16'h0);
        bus_idle();
        tick(2);

        // Misses while ARMED: out of window, virtual mode off, interrupt acknowledge
        io_out(16'h0050, 8'h11);
        tick(2);
        bus_idle();
        tick(2);
        chk("miss50_ovr", 16'(trap_overrun), 16'h0);
        virtual_mode = 1'b0;
        io_out(16'h0043, 8'h22);
        tick(2);
        bus_idle();
        tick(2);
        chk("vm0_ovr", 16'(trap_overrun), 16'h0);
        chk("vm0_keep_cond", 16'(trap_condition), 16'h1);
        virtual_mode = 1'b1;
        addr = 16'h0041; m1_n = 1'b0; iorq_n = 1'b0;
        tick(2);
        bus_idle();
        tick(2);
        chk("inta_ovr", 16'(trap_overrun), 16'h0);
        chk("inta_port", 16'(trap_port), 16'h41);

        // Non-NMI fetch is ignored while ARMED
        mem_rd(16'h1234, 1'b1);
        tick(2);
        chk("fetch_other_en", 16'(inject_en), 16'h0);
        bus_idle();
        tick(2);

        // NMI fetch: JP opcode
        mem_rd(16'h0066, 1'b1);
        tick(2);
        chk("nmi_new_isr", 16'(new_isr), 16'h1);
        chk("nmi_inj_en", 16'(inject_en), 16'h1);
        chk("nmi_inj_c3", 16'(inject_data), 16'hC3);
        tick(1);
        chk("nmi_new_isr_w", 16'(new_isr), 16'h0);
        chk("nmi_inj_hold", 16'(inject_en), 16'h1);
        bus_idle();
        tick(2);
        chk("op_end_en", 16'(inject_en), 16'h0);
        chk("op_end_lo", 16'(inject_data), 16'h00);

        // Refresh in LO does not advance
        addr = 16'h0005; mreq_n = 1'b0;
        tick(2);
        chk("rfsh_en", 16'(inject_en), 16'h0);
        bus_idle();
        tick(2);

        // Second OUT while in LO: dropped
        io_out(16'h0042, 8'h77);
        tick(2);
        chk("ovr_set", 16'(trap_overrun), 16'h1);
        chk("ovr_port", 16'(trap_port), 16'h41);
        chk("ovr_data", 16'(trap_data), 16'(EXP_WD));
        bus_idle();
        tick(2);

        // MRD 0x0067: low operand byte
        mem_rd(16'h0067, 1'b0);
        tick(2);
        chk("lo_en", 16'(inject_en), 16'h1);
        chk("lo_byte", 16'(inject_data), 16'h00);
        bus_idle();
        tick(2);
        chk("lo_end_en", 16'(inject_en), 16'h0);
        chk("hi_byte_ld", 16'(inject_data), 16'h01);

        // MRD 0x0068: high operand byte, then completion
        mem_rd(16'h0068, 1'b0);
        tick(2);
        chk("hi_en", 16'(inject_en), 16'h1);
        chk("hi_byte", 16'(inject_data), 16'h01);
        chk("hi_cond", 16'(trap_condition), 16'h1);
        bus_idle();
        tick(2);
        chk("last_pulse", 16'(last_isr_jmp), 16'h1);
        chk("done_cond", 16'(trap_condition), 16'h0);
        tick(1);
        chk("last_pulse_w", 16'(last_isr_jmp), 16'h0);
        chk("n_new_1", 16'(n_new), 16'h1);
        chk("n_last_1", 16'(n_last), 16'h1);

        // Trapped IN from 0x45
        io_in(16'h0045);
        tick(2);
        chk("in_en", 16'(inject_en), 16'h1);
        chk("in_ff", 16'(inject_data), 16'hFF);
        chk("in_dir", 16'(trap_dir), 16'h0);
        chk("in_port", 16'(trap_port), 16'h45);
        chk("in_cond", 16'(trap_condition), 16'h1);
        tick(2);
        chk("in_en_hold", 16'(inject_en), 16'h1);
        bus_idle();
        tick(2);
        chk("in_end_en", 16'(inject_en), 16'h0);
        chk("ovr_sticky", 16'(trap_overrun), 16'h1);

        // Reset during OP
        mem_rd(16'h0066, 1'b1);
        tick(2);
        chk("op2_en", 16'(inject_en), 16'h1);
        rst = 1'b1;
        tick(1);
        chk("rst_op_en", 16'(inject_en), 16'h0);
        chk("rst_op_cond", 16'(trap_condition), 16'h0);
        chk("rst_op_ovr", 16'(trap_overrun), 16'h0);
        rst = 1'b0;
        bus_idle();
        tick(3);
        mem_rd(16'h0066, 1'b1);
        tick(2);
        chk("post_rst_en", 16'(inject_en), 16'h0);
        chk("post_rst_isr", 16'(new_isr), 16'h0);
        bus_idle();
        tick(2);
        chk("n_new_2", 16'(n_new), 16'h2);

        // No trap from IDLE: IN 0x50, virtual mode off, interrupt acknowledge
        io_in(16'h0050);
        tick(2);
        chk("in50_en", 16'(inject_en), 16'h0);
        chk("in50_cond", 16'(trap_condition), 16'h0);
        bus_idle();
        tick(2);
        virtual_mode = 1'b0;
        io_out(16'h0041, 8'h33);
        tick(2);
        chk("vm0_idle_cond", 16'(trap_condition), 16'h0);
        bus_idle();
        virtual_mode = 1'b1;
        tick(2);
        addr = 16'h0041; m1_n = 1'b0; iorq_n = 1'b0;
        tick(2);
        chk("inta_idle_cond", 16'(trap_condition), 16'h0);
        chk("inta_idle_port", 16'(trap_port), 16'h00);
        bus_idle();
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
